// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the serial subtractor datapath.
//   bcd_digit_t  : one packed BCD digit
//   BCD_NINE     : largest legal digit value
//   BCD_TEN      : decimal correction threshold for a 5-bit digit sum
//   nines_comp   : 9 - d for a legal digit
//   digit_valid  : 1 when d is a legal BCD digit (0..9)
//   sub_state_t  : controller states of bcd_serial_subtractor
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam logic [4:0] BCD_TEN  = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        NEGATE,
        DONE
    } sub_state_t;

    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_NINE - d;
    endfunction

    function automatic logic digit_valid(input bcd_digit_t d);
        return (d <= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with carry, purely combinational.
//   a, b : BCD digit operands (0..9)
//   cin  : carry in
//   s    : BCD sum digit
//   cout : decimal carry out (binary sum exceeded 9)
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] bin_sum;

    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (bin_sum >= BCD_TEN) begin
            // bin_sum is 10..19, so the low nibble plus 6 wraps to bin_sum - 10
            cout = 1'b1;
            s    = bin_sum[3:0] + 4'd6;
        end else begin
            cout = 1'b0;
            s    = bin_sum[3:0];
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: computes |A - B| one digit per clock, LSD first,
// as A + nines_comp(B) + 1, followed by a 10's-complement pass when A < B.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : request, only honoured in IDLE
//   a_bcd     : minuend, digit i at [4i+3:4i], captured on accepted start
//   b_bcd     : subtrahend, same layout
//   busy      : high while the ADD or NEGATE pass is running
//   done      : one-cycle completion pulse; results valid from this cycle
//   diff_bcd  : magnitude of A - B
//   negative  : A < B
//   invalid   : a captured digit of A or B was greater than 9
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a_bcd,
    input  logic [4*NDIGITS-1:0]   b_bcd,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff_bcd,
    output logic                   negative,
    output logic                   invalid
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    sub_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [4*NDIGITS-1:0]  a_reg;
    logic [4*NDIGITS-1:0]  b_reg;
    logic [4*NDIGITS-1:0]  r_reg;
    logic [4*NDIGITS-1:0]  r_next;
    logic                  any_bad;

    bcd_digit_t add_a;
    bcd_digit_t add_b;
    bcd_digit_t add_s;
    logic       add_cout;

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (!digit_valid(a_bcd[4*i +: 4]) || !digit_valid(b_bcd[4*i +: 4]))
                any_bad = 1'b1;
        end
    end

    // One adder serves both passes: ADD feeds A[i] + 9's(B[i]),
    // NEGATE feeds 9's(r[i]) + 0; the pass carry provides the +1.
    always_comb begin
        if (state == NEGATE) begin
            add_a = nines_comp(r_reg[4*idx +: 4]);
            add_b = '0;
        end else begin
            add_a = a_reg[4*idx +: 4];
            add_b = nines_comp(b_reg[4*idx +: 4]);
        end
    end

    bcd_digit_adder u_digit_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        r_next               = r_reg;
        r_next[4*idx +: 4]   = add_s;
    end

    assign busy = (state == ADD) || (state == NEGATE);
    assign done = (state == DONE);

    // diff_bcd is loaded on the edge that enters DONE, so it is valid
    // together with the done pulse and is never exposed mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            diff_bcd <= '0;
            negative <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a_bcd;
                        b_reg    <= b_bcd;
                        negative <= 1'b0;
                        if (any_bad) begin
                            invalid  <= 1'b1;
                            diff_bcd <= '0;
                            state    <= DONE;
                        end else begin
                            invalid <= 1'b0;
                            idx     <= '0;
                            carry   <= 1'b1;
                            state   <= ADD;
                        end
                    end
                end
                ADD: begin
                    r_reg <= r_next;
                    if (idx == LAST_IDX) begin
                        if (add_cout) begin
                            diff_bcd <= r_next;
                            state    <= DONE;
                        end else begin
                            idx      <= '0;
                            carry    <= 1'b1;
                            negative <= 1'b1;
                            state    <= NEGATE;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= add_cout;
                    end
                end
                NEGATE: begin
                    r_reg <= r_next;
                    if (idx == LAST_IDX) begin
                        diff_bcd <= r_next;
                        state    <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= add_cout;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4*ND-1:0] a_bcd;
    logic [4*ND-1:0] b_bcd;
    logic            busy;
    logic            done;
    logic [4*ND-1:0] diff_bcd;
    logic            negative;
    logic            invalid;

    int tests  = 0;
    int failed = 0;

    bcd_serial_subtractor #(.NDIGITS(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .busy     (busy),
        .done     (done),
        .diff_bcd (diff_bcd),
        .negative (negative),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        neg;
        logic        inv;
        int          lat;
        int          busy_cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on decimal values.
    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        int          t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        int   av, bv;
        v.a = a;
        v.b = b;
        if (has_bad(a) || has_bad(b)) begin
            v.diff = '0; v.neg = 1'b0; v.inv = 1'b1; v.lat = 1; v.busy_cycles = 0;
        end else begin
            av = bcd_to_int(a);
            bv = bcd_to_int(b);
            v.inv = 1'b0;
            v.neg = (av < bv);
            v.diff = int_to_bcd(v.neg ? bv - av : av - bv);
            v.lat = v.neg ? 2 * ND + 1 : ND + 1;
            v.busy_cycles = v.lat - 1;
        end
        return v;
    endfunction

    // Starts one operation and waits (bounded) for done; cycle 1 is the
    // cycle after the accepting edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output logic n, output logic i,
                          output int lat, output int bcnt, output logic after);
        @(negedge clk);
        a_bcd = a; b_bcd = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin lat = c; break; end
            bcnt += int'(busy);
            @(posedge clk); #1;
        end
        d = diff_bcd; n = negative; i = invalid;
        @(posedge clk); #1;
        after = done;
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        logic [15:0] d;
        logic        n, i, after;
        int          lat, bcnt;
        run_op(v.a, v.b, d, n, i, lat, bcnt, after);
        check({tag, " latency"},  32'(lat), 32'(v.lat));
        check({tag, " diff"},     32'(d), 32'(v.diff));
        check({tag, " negative"}, 32'(n), 32'(v.neg));
        check({tag, " invalid"},  32'(i), 32'(v.inv));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(v.busy_cycles));
        check({tag, " done_single"}, 32'(after), 32'(0));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] d;
        int          lat, pulses;

        vecs[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5, 4};
        vecs[1] = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 9, 8};
        vecs[2] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9, 8};
        vecs[3] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5, 4};
        vecs[4] = '{16'h0700, 16'h0700, 16'h0000, 1'b0, 1'b0, 5, 4};
        vecs[5] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 0};
        vecs[6] = '{16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 5, 4};

        rst = 1'b1; start = 1'b0; a_bcd = '0; b_bcd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",     32'(busy), 32'(0));
        check("reset done",     32'(done), 32'(0));
        check("reset diff",     32'(diff_bcd), 32'(0));
        check("reset negative", 32'(negative), 32'(0));
        check("reset invalid",  32'(invalid), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_and_check($sformatf("vec%0d", k), vecs[k]);

        // start while busy must be ignored
        @(negedge clk);
        a_bcd = 16'h5432; b_bcd = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; pulses = 0; d = '0;
        for (int c = 1; c <= 15; c++) begin
            if (done) begin
                pulses++;
                if (lat == 0) begin lat = c; d = diff_bcd; end
            end
            if (c == 1) begin
                @(negedge clk);
                a_bcd = 16'h0000; b_bcd = 16'h9999; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("ignore latency", 32'(lat), 32'(5));
        check("ignore diff",    32'(d), 32'h4198);
        check("ignore pulses",  32'(pulses), 32'(1));

        // reset in the third ADD cycle aborts without a done pulse
        @(negedge clk);
        a_bcd = 16'h5432; b_bcd = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy",     32'(busy), 32'(0));
        check("abort done",     32'(done), 32'(0));
        check("abort diff",     32'(diff_bcd), 32'(0));
        check("abort negative", 32'(negative), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        check("abort no_done", 32'(pulses), 32'(0));
        run_and_check("post_abort", vecs[1]);

        // randomized operands against the arithmetic model
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < ND; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    ra[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
                else
                    rb[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
            end
            run_and_check($sformatf("rand%0d", k), model(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
